// File: rtl/dtack_generator.sv
// Wait-stated DTACK_L / BERR_L generator for one 68000 bus master.
// Decoder selects are latched on the start edge; device acknowledges are registered one clock before use.
module dtack_generator #(
  parameter int ROM_WAIT      = 1,
  parameter int RAM_WAIT      = 1,
  parameter int IO_WAIT       = 2,
  parameter int GFX_WAIT      = 3,
  parameter int OFFBOARD_WAIT = 4,
  parameter int DMA_WAIT      = 2,
  parameter int TIMEOUT       = 255,
  parameter int CNT_W         = 8
) (
  input  logic Clk,
  input  logic Reset_L,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic DramSelect_H,
  input  logic IOSelect_H,
  input  logic CanBusSelect_H,
  input  logic DMASelect_L,
  input  logic GraphicsCS_L,
  input  logic OffBoardMemory_H,
  input  logic DramDtack_L,
  input  logic CanBusDtack_L,
  output logic DTACK_L,
  output logic BERR_L,
  output logic Busy_H
);

  localparam int MAXV = (1 << CNT_W) - 1;

  if (ROM_WAIT < 0 || ROM_WAIT > MAXV || RAM_WAIT < 0 || RAM_WAIT > MAXV ||
      IO_WAIT < 0 || IO_WAIT > MAXV || GFX_WAIT < 0 || GFX_WAIT > MAXV ||
      OFFBOARD_WAIT < 0 || OFFBOARD_WAIT > MAXV || DMA_WAIT < 0 || DMA_WAIT > MAXV ||
      TIMEOUT < 1 || TIMEOUT > MAXV) begin : g_bad_cfg
    $error("dtack_generator: wait or timeout parameter does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] L_ROM = CNT_W'(ROM_WAIT);
  localparam logic [CNT_W-1:0] L_RAM = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] L_IO  = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] L_GFX = CNT_W'(GFX_WAIT);
  localparam logic [CNT_W-1:0] L_OFF = CNT_W'(OFFBOARD_WAIT);
  localparam logic [CNT_W-1:0] L_DMA = CNT_W'(DMA_WAIT);
  localparam logic [CNT_W-1:0] L_TMO = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_EXTWAIT = 3'd2,
    S_NOMAP   = 3'd3,
    S_ACK     = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_is_can;
  logic             w_is_can_nxt;
  logic             r_dram_dtack_l;
  logic             r_can_dtack_l;
  logic             r_dtack_l;
  logic             r_berr_l;
  logic             w_start;
  logic             w_dev_ack;
  logic             w_cnt_zero;

  assign w_start    = ~AS_L & (~UDS_L | ~LDS_L);
  assign w_dev_ack  = r_is_can ? ~r_can_dtack_l : ~r_dram_dtack_l;
  assign w_cnt_zero = (r_count == '0);

  always_comb begin
    w_next       = r_state;
    w_count_nxt  = r_count;
    w_is_can_nxt = r_is_can;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          // Priority chain: first active select wins, the rest are ignored
          if (OnChipRomSelect_H) begin
            w_next = S_WAIT; w_count_nxt = L_ROM;
          end else if (OnChipRamSelect_H) begin
            w_next = S_WAIT; w_count_nxt = L_RAM;
          end else if (IOSelect_H) begin
            w_next = S_WAIT; w_count_nxt = L_IO;
          end else if (CanBusSelect_H) begin
            w_next = S_EXTWAIT; w_count_nxt = L_TMO; w_is_can_nxt = 1'b1;
          end else if (DramSelect_H) begin
            w_next = S_EXTWAIT; w_count_nxt = L_TMO; w_is_can_nxt = 1'b0;
          end else if (~DMASelect_L) begin
            w_next = S_WAIT; w_count_nxt = L_DMA;
          end else if (~GraphicsCS_L) begin
            w_next = S_WAIT; w_count_nxt = L_GFX;
          end else if (OffBoardMemory_H) begin
            w_next = S_WAIT; w_count_nxt = L_OFF;
          end else begin
            w_next = S_NOMAP; w_count_nxt = L_TMO;
          end
        end
      end
      S_WAIT: begin
        if (AS_L)            w_next = S_IDLE;
        else if (w_cnt_zero) w_next = S_ACK;
        else                 w_count_nxt = r_count - CNT_W'(1);
      end
      S_EXTWAIT: begin
        if (AS_L)            w_next = S_IDLE;
        else if (w_dev_ack)  w_next = S_ACK;
        else if (w_cnt_zero) w_next = S_ERR;
        else                 w_count_nxt = r_count - CNT_W'(1);
      end
      S_NOMAP: begin
        if (AS_L)            w_next = S_IDLE;
        else if (w_cnt_zero) w_next = S_ERR;
        else                 w_count_nxt = r_count - CNT_W'(1);
      end
      S_ACK, S_ERR: begin
        if (AS_L) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the transition edge
  always_ff @(posedge Clk) begin
    if (!Reset_L) begin
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_is_can       <= 1'b0;
      r_dram_dtack_l <= 1'b1;
      r_can_dtack_l  <= 1'b1;
      r_dtack_l      <= 1'b1;
      r_berr_l       <= 1'b1;
    end else begin
      r_state        <= w_next;
      r_count        <= w_count_nxt;
      r_is_can       <= w_is_can_nxt;
      r_dram_dtack_l <= DramDtack_L;
      r_can_dtack_l  <= CanBusDtack_L;
      r_dtack_l      <= (w_next != S_ACK);
      r_berr_l       <= (w_next != S_ERR);
    end
  end

  assign DTACK_L = r_dtack_l;
  assign BERR_L  = r_berr_l;
  assign Busy_H  = (r_state != S_IDLE);

endmodule

// File: tb/tb_dtack_generator.sv
// Bench for dtack_generator: directed vector table, hand-written corner sequences,
// then random bus traffic compared against an edge-arithmetic transaction model.
module tb_dtack_generator;

  localparam int TMO   = 16;
  localparam int W_ROM = 1;
  localparam int W_RAM = 1;
  localparam int W_IO  = 2;
  localparam int W_GFX = 3;
  localparam int W_OFF = 4;
  localparam int W_DMA = 2;

  localparam logic [7:0] S_ROM  = 8'h80;
  localparam logic [7:0] S_RAM  = 8'h40;
  localparam logic [7:0] S_IO   = 8'h20;
  localparam logic [7:0] S_CAN  = 8'h10;
  localparam logic [7:0] S_DRAM = 8'h08;
  localparam logic [7:0] S_DMA  = 8'h04;
  localparam logic [7:0] S_GFX  = 8'h02;
  localparam logic [7:0] S_OFF  = 8'h01;

  logic       Clk = 1'b0;
  logic       Reset_L, AS_L, UDS_L, LDS_L, DramDtack_L, CanBusDtack_L;
  logic [7:0] sel;
  logic       OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, CanBusSelect_H;
  logic       DramSelect_H, DMASelect_L, GraphicsCS_L, OffBoardMemory_H;
  logic       DTACK_L, BERR_L, Busy_H;

  assign OnChipRomSelect_H = sel[7];
  assign OnChipRamSelect_H = sel[6];
  assign IOSelect_H        = sel[5];
  assign CanBusSelect_H    = sel[4];
  assign DramSelect_H      = sel[3];
  assign DMASelect_L       = ~sel[2];
  assign GraphicsCS_L      = ~sel[1];
  assign OffBoardMemory_H  = sel[0];

  always #5 Clk = ~Clk;

  dtack_generator #(
    .ROM_WAIT(W_ROM), .RAM_WAIT(W_RAM), .IO_WAIT(W_IO), .GFX_WAIT(W_GFX),
    .OFFBOARD_WAIT(W_OFF), .DMA_WAIT(W_DMA), .TIMEOUT(TMO), .CNT_W(8)
  ) dut (
    .Clk(Clk), .Reset_L(Reset_L), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
    .OnChipRomSelect_H(OnChipRomSelect_H), .OnChipRamSelect_H(OnChipRamSelect_H),
    .DramSelect_H(DramSelect_H), .IOSelect_H(IOSelect_H), .CanBusSelect_H(CanBusSelect_H),
    .DMASelect_L(DMASelect_L), .GraphicsCS_L(GraphicsCS_L), .OffBoardMemory_H(OffBoardMemory_H),
    .DramDtack_L(DramDtack_L), .CanBusDtack_L(CanBusDtack_L),
    .DTACK_L(DTACK_L), .BERR_L(BERR_L), .Busy_H(Busy_H)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Transaction model: a cycle that starts on edge s resolves on a fixed edge
  // number (s+W+1, or s+TIMEOUT+1), or one edge after the device ack is seen.
  bit   m_active = 1'b0;
  logic m_dt = 1'b1, m_be = 1'b1;
  int   m_kind = 0;
  int   m_deadline = 0;
  int   m_edge = 0;
  logic m_pd = 1'b1, m_pc = 1'b1;

  task automatic model_step();
    int hit;
    if (!Reset_L) begin
      m_active = 1'b0; m_dt = 1'b1; m_be = 1'b1; m_pd = 1'b1; m_pc = 1'b1;
    end else begin
      if (!m_active) begin
        if (!AS_L && (!UDS_L || !LDS_L)) begin
          hit = -1;
          for (int i = 7; i >= 0; i--) if (sel[i] && hit < 0) hit = i;
          m_active = 1'b1;
          case (hit)
            7: begin m_kind = 0; m_deadline = m_edge + W_ROM + 1; end
            6: begin m_kind = 0; m_deadline = m_edge + W_RAM + 1; end
            5: begin m_kind = 0; m_deadline = m_edge + W_IO  + 1; end
            4: begin m_kind = 2; m_deadline = m_edge + TMO   + 1; end
            3: begin m_kind = 1; m_deadline = m_edge + TMO   + 1; end
            2: begin m_kind = 0; m_deadline = m_edge + W_DMA + 1; end
            1: begin m_kind = 0; m_deadline = m_edge + W_GFX + 1; end
            0: begin m_kind = 0; m_deadline = m_edge + W_OFF + 1; end
            default: begin m_kind = 3; m_deadline = m_edge + TMO + 1; end
          endcase
        end
      end else if (AS_L) begin
        m_active = 1'b0; m_dt = 1'b1; m_be = 1'b1;
      end else if (m_dt && m_be) begin
        if (m_kind == 0) begin
          if (m_edge == m_deadline) m_dt = 1'b0;
        end else if ((m_kind == 1 && !m_pd) || (m_kind == 2 && !m_pc)) begin
          m_dt = 1'b0;
        end else if (m_edge == m_deadline) begin
          m_be = 1'b0;
        end
      end
      m_pd = DramDtack_L;
      m_pc = CanBusDtack_L;
    end
    m_edge++;
  endtask

  task automatic adv();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic as_l, input logic uds_l, input logic lds_l,
                       input logic [7:0] s, input logic dk, input logic ck);
    AS_L = as_l; UDS_L = uds_l; LDS_L = lds_l; sel = s; DramDtack_L = dk; CanBusDtack_L = ck;
  endtask

  typedef struct {
    logic       rst, as_l, uds_l, lds_l;
    logic [7:0] s;
    logic       dk, ck;
    logic       dt, be, busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic as_l, input logic uds_l, input logic lds_l,
                              input logic [7:0] s, input logic dt, input logic be, input logic busy);
    vec_t v;
    v.rst = rst; v.as_l = as_l; v.uds_l = uds_l; v.lds_l = lds_l; v.s = s;
    v.dk = 1'b1; v.ck = 1'b1; v.dt = dt; v.be = be; v.busy = busy;
    return v;
  endfunction

  initial begin
    int   falls;
    logic prev;
    Reset_L = 1'b0;
    drive(1, 1, 1, 8'h00, 1, 1);

    // Reset, ROM read, ROM+IO priority, graphics wait, strobes idle
    tbl.push_back(mk(0, 1, 1, 1, 8'h00, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 8'h00, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, S_ROM, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, S_ROM, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, S_ROM, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, S_ROM, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, S_ROM, 0, 1, 1));
    tbl.push_back(mk(1, 1, 1, 1, S_ROM, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 8'h00, 1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, S_ROM | S_IO, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0, S_ROM | S_IO, 1, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0, S_ROM | S_IO, 0, 1, 1));
    tbl.push_back(mk(1, 1, 1, 1, 8'h00, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, S_GFX, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, S_GFX, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, S_GFX, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, S_GFX, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, S_GFX, 0, 1, 1));
    tbl.push_back(mk(1, 1, 1, 1, 8'h00, 1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 1, S_ROM, 1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 1, S_ROM, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 8'h00, 1, 1, 0));

    foreach (tbl[i]) begin
      Reset_L = tbl[i].rst;
      drive(tbl[i].as_l, tbl[i].uds_l, tbl[i].lds_l, tbl[i].s, tbl[i].dk, tbl[i].ck);
      adv();
      chk($sformatf("tbl%0d_dtack", i), DTACK_L, tbl[i].dt);
      chk($sformatf("tbl%0d_berr", i), BERR_L, tbl[i].be);
      chk($sformatf("tbl%0d_busy", i), Busy_H, tbl[i].busy);
    end

    // DRAM ack sampled at edge 7 -> DTACK_L low after edge 8
    drive(0, 0, 0, S_DRAM, 1, 1);
    for (int e = 0; e < 7; e++) adv();
    drive(0, 0, 0, S_DRAM, 0, 1);
    adv();
    chk("dram_ack_e7", DTACK_L, 1);
    adv();
    chk("dram_ack_e8", DTACK_L, 0);
    chk("dram_ack_berr", BERR_L, 1);
    drive(1, 1, 1, 8'h00, 1, 1);
    adv();
    chk("dram_ack_release", DTACK_L, 1);

    // DRAM never acks -> BERR_L after edge TIMEOUT+1
    drive(0, 0, 1, S_DRAM, 1, 1);
    for (int e = 0; e <= TMO; e++) adv();
    chk("dram_to_e16", BERR_L, 1);
    adv();
    chk("dram_to_e17_berr", BERR_L, 0);
    chk("dram_to_e17_dtack", DTACK_L, 1);
    adv();
    chk("dram_to_hold", BERR_L, 0);
    drive(1, 1, 1, 8'h00, 1, 1);
    adv();
    chk("dram_to_release", BERR_L, 1);

    // CAN outranks DRAM: a DRAM ack must not complete a CAN cycle
    drive(0, 0, 0, S_CAN | S_DRAM, 0, 1);
    for (int e = 0; e < 3; e++) adv();
    drive(0, 0, 0, S_CAN | S_DRAM, 0, 0);
    adv();
    chk("can_e3", DTACK_L, 1);
    adv();
    chk("can_e4", DTACK_L, 0);
    drive(1, 1, 1, 8'h00, 1, 1);
    adv();

    // Unmapped address
    drive(0, 0, 0, 8'h00, 1, 1);
    for (int e = 0; e <= TMO; e++) adv();
    chk("nomap_e16", BERR_L, 1);
    adv();
    chk("nomap_e17", BERR_L, 0);
    drive(1, 1, 1, 8'h00, 1, 1);
    adv();
    chk("nomap_release_berr", BERR_L, 1);
    chk("nomap_release_busy", Busy_H, 0);

    // Abort of an off-board cycle: no pulse afterwards
    drive(0, 0, 0, S_OFF, 1, 1);
    adv(); adv();
    drive(1, 1, 1, S_OFF, 1, 1);
    adv();
    chk("abort_busy", Busy_H, 0);
    for (int e = 3; e < 7; e++) begin
      adv();
      chk($sformatf("abort_nopulse_e%0d", e), DTACK_L, 1);
    end

    // Reset while in ACK
    drive(0, 1, 0, S_RAM, 1, 1);
    adv(); adv(); adv();
    chk("rst_ack_e2", DTACK_L, 0);
    Reset_L = 1'b0;
    drive(1, 1, 1, 8'h00, 1, 1);
    adv();
    chk("rst_ack_dtack", DTACK_L, 1);
    chk("rst_ack_busy", Busy_H, 0);
    Reset_L = 1'b1;
    adv();

    // Select change after start is ignored
    drive(0, 0, 0, S_ROM, 1, 1);
    adv();
    drive(0, 0, 0, S_GFX, 1, 1);
    adv();
    chk("selchg_e1", DTACK_L, 1);
    adv();
    chk("selchg_e2", DTACK_L, 0);
    drive(1, 1, 1, 8'h00, 1, 1);
    adv();

    // Held strobe: exactly one acknowledge over 20 clocks
    drive(0, 0, 0, S_IO, 1, 1);
    falls = 0;
    prev = DTACK_L;
    for (int e = 0; e < 20; e++) begin
      adv();
      if (prev === 1'b1 && DTACK_L === 1'b0) falls++;
      prev = DTACK_L;
      if (e == 2) chk("held_e2", DTACK_L, 1);
      if (e == 3) chk("held_e3", DTACK_L, 0);
    end
    chk("held_one_ack", falls, 1);
    drive(1, 1, 1, S_IO, 1, 1);
    adv();
    chk("held_release", Busy_H, 0);
    drive(0, 0, 0, S_IO, 1, 1);
    for (int e = 0; e < 3; e++) adv();
    chk("second_e2", DTACK_L, 1);
    adv();
    chk("second_e3", DTACK_L, 0);
    drive(1, 1, 1, 8'h00, 1, 1);
    adv();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      Reset_L = ($urandom_range(0, 199) != 0);
      AS_L = ($urandom_range(0, 7) == 0);
      UDS_L = $urandom_range(0, 1);
      LDS_L = $urandom_range(0, 1);
      for (int b = 0; b < 8; b++) sel[b] = ($urandom_range(0, 3) == 0);
      DramDtack_L = ($urandom_range(0, 9) != 0);
      CanBusDtack_L = ($urandom_range(0, 9) != 0);
      adv();
      chk($sformatf("rnd%0d_dtack", n), DTACK_L, m_dt);
      chk($sformatf("rnd%0d_berr", n), BERR_L, m_be);
      chk($sformatf("rnd%0d_busy", n), Busy_H, m_active);
      chk($sformatf("rnd%0d_excl", n), DTACK_L | BERR_L, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
